// File: rtl/riscv_mem_sequencer_pkg.sv
// Shared definitions for the RV32 memory sequencer: state encoding, access
// width codes, fault cause codes, reset instruction word and alignment helper.
// Pure package, no logic.
package riscv_mem_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_DATA   = 3'd2,
    S_COMMIT = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam logic [1:0] W_NONE = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_FETCH   = 2'd1;
  localparam logic [1:0] CAUSE_DATA    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] off);
    return ((width == W_HALF) && off[0]) || ((width == W_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/riscv_mem_sequencer_if.sv
// Core-side and memory-side signals of the sequencer bundled in one interface.
// master = the sequencer itself, slave = the core plus memory around it.
// No logic; direction only.
interface riscv_mem_sequencer_if #(
  parameter int COUNT_WIDTH = 32
);
  // core side
  logic [31:0]            instruction_address;
  logic [31:0]            instruction_data;
  logic [31:0]            data_address;
  logic [1:0]             data_width;
  logic [31:0]            data_out;
  logic                   data_read;
  logic                   data_write;
  logic [31:0]            data_in;
  logic                   core_stall;
  logic                   core_wait;
  // memory side
  logic                   mem_req;
  logic                   mem_we;
  logic [29:0]            mem_addr;
  logic [3:0]             mem_be;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;
  logic                   mem_ready;
  // status
  logic                   fault;
  logic [1:0]             fault_cause;
  logic [COUNT_WIDTH-1:0] instret;

  modport master (
    input  instruction_address, data_address, data_width, data_out,
           data_read, data_write, core_stall, mem_rdata, mem_ready,
    output instruction_data, data_in, core_wait, mem_req, mem_we,
           mem_addr, mem_be, mem_wdata, fault, fault_cause, instret
  );

  modport slave (
    output instruction_address, data_address, data_width, data_out,
           data_read, data_write, core_stall, mem_rdata, mem_ready,
    input  instruction_data, data_in, core_wait, mem_req, mem_we,
           mem_addr, mem_be, mem_wdata, fault, fault_cause, instret
  );

endinterface

// File: rtl/riscv_mem_sequencer_lanes.sv
// Byte-lane steering: byte enables and shifted store data, plus load alignment.
// Purely combinational, zero latency.
// No flow control; the caller decides when the results are used.
module riscv_mem_sequencer_lanes
  import riscv_mem_sequencer_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  wr_off_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rd_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Enables from width and byte offset; data moved by whole bytes.
  always_comb begin
    be_o = 4'b0000;
    case (width_i)
      W_BYTE:  be_o = 4'b0001 << wr_off_i;
      W_HALF:  be_o = 4'b0011 << wr_off_i;
      W_WORD:  be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
    wdata_o = wdata_i << {wr_off_i, 3'b000};
    rdata_o = rdata_i >> {rd_off_i, 3'b000};
  end

endmodule

// File: rtl/riscv_mem_sequencer.sv
// Steps a single-cycle RV32 core through FETCH/EXEC/[DATA]/COMMIT on one memory port.
// Latency: 2 cycles per ALU instruction, 4 per load/store with zero-wait memory.
// Backpressure: mem_ready stretches FETCH/DATA (with timeout), core_stall holds EXEC/COMMIT.
module riscv_mem_sequencer
  import riscv_mem_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset,
  riscv_mem_sequencer_if.master bus
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_e                 state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            din_q, din_d;
  logic [COUNT_WIDTH-1:0] instret_q, instret_d;
  logic [1:0]             cause_q, cause_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   we_q, we_d;
  logic [29:0]            addr_q, addr_d;
  logic [3:0]             be_q, be_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [1:0]             off_q, off_d;

  logic                   mem_req;
  logic                   core_wait;
  logic                   access;
  logic [3:0]             lane_be;
  logic [31:0]            lane_wdata;
  logic [31:0]            lane_rdata;

  riscv_mem_sequencer_lanes u_lanes (
    .width_i  (bus.data_width),
    .wr_off_i (bus.data_address[1:0]),
    .wdata_i  (bus.data_out),
    .rd_off_i (off_q),
    .rdata_i  (bus.mem_rdata),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  assign access = (bus.data_read || bus.data_write) && (bus.data_width != W_NONE);

  // Next-state, request and core handshake; timeout overrides the phase result.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    din_d     = din_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    to_d      = to_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    off_d     = off_q;
    mem_req   = 1'b0;
    core_wait = 1'b1;

    case (state_q)
      S_FETCH: begin
        if (bus.instruction_address[1:0] != 2'b00) begin
          state_d = S_FAULT;
          cause_d = CAUSE_FETCH;
        end else begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            instr_d = bus.mem_rdata;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (!access) begin
          core_wait = bus.core_stall;
          if (!bus.core_stall) begin
            instret_d = instret_q + COUNT_WIDTH'(1);
            state_d   = S_FETCH;
          end
        end else if (misaligned(bus.data_width, bus.data_address[1:0])) begin
          state_d = S_FAULT;
          cause_d = CAUSE_DATA;
        end else begin
          // read+write together resolves to a write
          we_d    = bus.data_write;
          addr_d  = bus.data_address[31:2];
          be_d    = lane_be;
          wdata_d = lane_wdata;
          off_d   = bus.data_address[1:0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          din_d   = we_q ? 32'h0 : lane_rdata;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        core_wait = bus.core_stall;
        if (!bus.core_stall) begin
          instret_d = instret_q + COUNT_WIDTH'(1);
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // Count unanswered request cycles; zero timeout disables the check.
    if (mem_req && !bus.mem_ready && (MEM_TIMEOUT != 0)) begin
      if (to_q == TO_LAST) begin
        state_d = S_FAULT;
        cause_d = CAUSE_TIMEOUT;
        to_d    = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  // State and datapath registers; reset drops any request in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instr_q   <= NOP_INSN;
      din_q     <= 32'h0;
      instret_q <= '0;
      cause_q   <= CAUSE_NONE;
      to_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= 30'h0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      off_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      din_q     <= din_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
      to_q      <= to_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      off_q     <= off_d;
    end
  end

  // Fetch drives pc fields, DATA drives the registered access; reset gates the request.
  assign bus.mem_req          = mem_req && !reset;
  assign bus.mem_we           = (state_q == S_DATA) && we_q;
  assign bus.mem_addr         = (state_q == S_DATA) ? addr_q : bus.instruction_address[31:2];
  assign bus.mem_be           = (state_q == S_DATA) ? be_q : 4'hF;
  assign bus.mem_wdata        = (state_q == S_DATA) ? wdata_q : 32'h0;
  assign bus.core_wait        = core_wait || reset;
  assign bus.instruction_data = instr_q;
  assign bus.data_in          = din_q;
  assign bus.fault            = (cause_q != CAUSE_NONE);
  assign bus.fault_cause      = cause_q;
  assign bus.instret          = instret_q;

endmodule

// File: tb/tb_riscv_mem_sequencer.sv
// Directed bench for riscv_mem_sequencer: the bench plays both core and memory.
// Each scenario starts from reset and checks its own hand-computed values.
module tb_riscv_mem_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  riscv_mem_sequencer_if #(.COUNT_WIDTH(32)) bus ();

  riscv_mem_sequencer #(.MEM_TIMEOUT(4), .COUNT_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    reset = 1'b1;
    bus.instruction_address = pc;
    bus.data_address = 32'h0;
    bus.data_width   = 2'd3;
    bus.data_out     = 32'h0;
    bus.data_read    = 1'b0;
    bus.data_write   = 1'b0;
    bus.core_stall   = 1'b0;
    bus.mem_rdata    = 32'h0;
    bus.mem_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Zero-wait fetch: returns one cycle later in EXEC.
  task automatic fetch_insn(input logic [31:0] insn);
    bus.mem_rdata = insn;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instruction_address = 32'h0;
    bus.data_width = 2'd3; bus.data_read = 1'b0; bus.data_write = 1'b0;
    bus.data_address = 32'h0; bus.data_out = 32'h0; bus.core_stall = 1'b0;
    bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;
    tick();
    n_cmp++; if (bus.instruction_data !== 32'h13) begin n_bad++; $display("FAIL rst_insn got=%h want=%h", bus.instruction_data, 32'h13); end
    n_cmp++; if (bus.data_in !== 32'h0) begin n_bad++; $display("FAIL rst_din got=%h want=0", bus.data_in); end
    n_cmp++; if (bus.core_wait !== 1'b1) begin n_bad++; $display("FAIL rst_wait got=%b want=1", bus.core_wait); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b want=0", bus.mem_req); end
    n_cmp++; if (bus.fault !== 1'b0 || bus.fault_cause !== 2'd0) begin n_bad++; $display("FAIL rst_fault got=%b/%0d want=0/0", bus.fault, bus.fault_cause); end
    n_cmp++; if (bus.instret !== 32'd0) begin n_bad++; $display("FAIL rst_instret got=%0d want=0", bus.instret); end
  endtask

  task automatic test_alu_only();
    do_reset(32'h0);
    bus.mem_rdata = 32'h0010_0093;
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL alu_req got=%b want=1", bus.mem_req); end
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF || bus.mem_addr !== 30'h0) begin n_bad++; $display("FAIL alu_fetch got we=%b be=%h a=%h want 0/f/0", bus.mem_we, bus.mem_be, bus.mem_addr); end
    n_cmp++; if (bus.core_wait !== 1'b1) begin n_bad++; $display("FAIL alu_wait_fetch got=%b want=1", bus.core_wait); end
    tick();
    bus.mem_ready = 1'b0;
    #1;
    n_cmp++; if (bus.instruction_data !== 32'h0010_0093) begin n_bad++; $display("FAIL alu_insn got=%h want=00100093", bus.instruction_data); end
    n_cmp++; if (bus.core_wait !== 1'b0) begin n_bad++; $display("FAIL alu_wait_exec got=%b want=0", bus.core_wait); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL alu_req_exec got=%b want=0", bus.mem_req); end
    tick();
    n_cmp++; if (bus.instret !== 32'd1) begin n_bad++; $display("FAIL alu_instret got=%0d want=1", bus.instret); end
    n_cmp++; if (bus.core_wait !== 1'b1) begin n_bad++; $display("FAIL alu_wait_after got=%b want=1", bus.core_wait); end
  endtask

  task automatic test_load_byte();
    do_reset(32'h200);
    fetch_insn(32'h1030_0083);
    bus.data_read = 1'b1; bus.data_width = 2'd0; bus.data_address = 32'h103;
    #1;
    n_cmp++; if (bus.core_wait !== 1'b1 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL lb_exec got wait=%b req=%b want 1/0", bus.core_wait, bus.mem_req); end
    tick();
    bus.data_address = 32'h0; bus.data_width = 2'd2;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL lb_req got req=%b we=%b want 1/0", bus.mem_req, bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 30'h40) begin n_bad++; $display("FAIL lb_addr got=%h want=40", bus.mem_addr); end
    n_cmp++; if (bus.mem_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got=%b want=1000", bus.mem_be); end
    bus.mem_rdata = 32'hAB00_0000; bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0; bus.data_read = 1'b0; bus.data_width = 2'd3;
    #1;
    n_cmp++; if (bus.data_in !== 32'h0000_00AB) begin n_bad++; $display("FAIL lb_din got=%h want=000000ab", bus.data_in); end
    n_cmp++; if (bus.core_wait !== 1'b0 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL lb_commit got wait=%b req=%b want 0/0", bus.core_wait, bus.mem_req); end
    tick();
    n_cmp++; if (bus.instret !== 32'd1) begin n_bad++; $display("FAIL lb_instret got=%0d want=1", bus.instret); end
  endtask

  task automatic test_store_half();
    do_reset(32'h300);
    fetch_insn(32'h0011_1123);
    bus.data_write = 1'b1; bus.data_width = 2'd1; bus.data_address = 32'h22; bus.data_out = 32'h1234;
    tick();
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL sh_req got req=%b we=%b want 1/1", bus.mem_req, bus.mem_we); end
    n_cmp++; if (bus.mem_be !== 4'b1100 || bus.mem_addr !== 30'h8) begin n_bad++; $display("FAIL sh_be got be=%b a=%h want 1100/8", bus.mem_be, bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 32'h1234_0000) begin n_bad++; $display("FAIL sh_wdata got=%h want=12340000", bus.mem_wdata); end
    bus.mem_rdata = 32'hFFFF_FFFF; bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0; bus.data_write = 1'b0; bus.data_width = 2'd3;
    #1;
    n_cmp++; if (bus.data_in !== 32'h0) begin n_bad++; $display("FAIL sh_din got=%h want=0", bus.data_in); end
    tick();
    n_cmp++; if (bus.instret !== 32'd1) begin n_bad++; $display("FAIL sh_instret got=%0d want=1", bus.instret); end
  endtask

  task automatic test_delay_stall();
    do_reset(32'h400);
    fetch_insn(32'h0100_2083);
    bus.data_read = 1'b1; bus.data_width = 2'd2; bus.data_address = 32'h10;
    tick();
    bus.data_address = 32'h55;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h4 || bus.mem_be !== 4'hF) begin n_bad++; $display("FAIL dly_hold%0d got req=%b a=%h be=%h want 1/4/f", i, bus.mem_req, bus.mem_addr, bus.mem_be); end
      tick();
    end
    bus.mem_rdata = 32'hCAFE_F00D; bus.mem_ready = 1'b1;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.fault !== 1'b0) begin n_bad++; $display("FAIL dly_last got req=%b fault=%b want 1/0", bus.mem_req, bus.fault); end
    tick();
    bus.mem_ready = 1'b0; bus.core_stall = 1'b1; bus.data_read = 1'b0; bus.data_width = 2'd3;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (bus.core_wait !== 1'b1 || bus.instret !== 32'd0 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL stall%0d got wait=%b ir=%0d req=%b want 1/0/0", i, bus.core_wait, bus.instret, bus.mem_req); end
      n_cmp++; if (bus.data_in !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL stall_din%0d got=%h want=cafef00d", i, bus.data_in); end
      tick();
    end
    bus.core_stall = 1'b0;
    #1;
    n_cmp++; if (bus.core_wait !== 1'b0) begin n_bad++; $display("FAIL stall_release got=%b want=0", bus.core_wait); end
    tick();
    n_cmp++; if (bus.instret !== 32'd1) begin n_bad++; $display("FAIL stall_instret got=%0d want=1", bus.instret); end
    tick();
    n_cmp++; if (bus.instret !== 32'd1) begin n_bad++; $display("FAIL stall_single got=%0d want=1", bus.instret); end
  endtask

  task automatic test_faults();
    // misaligned word load
    do_reset(32'h500);
    fetch_insn(32'h0020_2083);
    bus.data_read = 1'b1; bus.data_width = 2'd2; bus.data_address = 32'h102;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL mis_noreq got=%b want=0", bus.mem_req); end
    tick();
    bus.data_read = 1'b0; bus.data_width = 2'd3;
    n_cmp++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'd2) begin n_bad++; $display("FAIL mis_data got=%b/%0d want=1/2", bus.fault, bus.fault_cause); end
    tick();
    tick();
    n_cmp++; if (bus.fault_cause !== 2'd2 || bus.mem_req !== 1'b0 || bus.core_wait !== 1'b1) begin n_bad++; $display("FAIL mis_sticky got c=%0d req=%b wait=%b want 2/0/1", bus.fault_cause, bus.mem_req, bus.core_wait); end
    // timeout on fetch, no ready ever
    do_reset(32'h600);
    tick();
    tick();
    tick();
    n_cmp++; if (bus.fault !== 1'b0 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL to_early got fault=%b req=%b want 0/1", bus.fault, bus.mem_req); end
    tick();
    n_cmp++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'd3 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL to_fault got f=%b c=%0d req=%b want 1/3/0", bus.fault, bus.fault_cause, bus.mem_req); end
    // misaligned pc
    do_reset(32'h702);
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL misfetch_req got=%b want=0", bus.mem_req); end
    tick();
    n_cmp++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'd1) begin n_bad++; $display("FAIL misfetch got=%b/%0d want=1/1", bus.fault, bus.fault_cause); end
  endtask

  task automatic test_reset_mid_data();
    do_reset(32'h800);
    fetch_insn(32'h0400_2083);
    bus.data_read = 1'b1; bus.data_width = 2'd2; bus.data_address = 32'h40;
    tick();
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h10) begin n_bad++; $display("FAIL rmd_data got req=%b a=%h want 1/10", bus.mem_req, bus.mem_addr); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.core_wait !== 1'b1) begin n_bad++; $display("FAIL rmd_drop got req=%b wait=%b want 0/1", bus.mem_req, bus.core_wait); end
    bus.instruction_address = 32'h900; bus.data_read = 1'b0; bus.data_width = 2'd3;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h240 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rmd_refetch got req=%b a=%h we=%b want 1/240/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    fetch_insn(32'h0000_0093);
    n_cmp++; if (bus.instruction_data !== 32'h93 || bus.core_wait !== 1'b0) begin n_bad++; $display("FAIL rmd_exec got i=%h wait=%b want 93/0", bus.instruction_data, bus.core_wait); end
    tick();
    n_cmp++; if (bus.instret !== 32'd1) begin n_bad++; $display("FAIL rmd_instret got=%0d want=1", bus.instret); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_load_byte();
    test_store_half();
    test_delay_stall();
    test_faults();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=expired want=finished");
    $fatal(1, "watchdog");
  end

endmodule
